uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter LOCK_TIMEOUT, default 1024: idle cycles a locked owner may hold the grant with req low before forced release.
REQ-002 The block SHALL have parameter START_TIMEOUT, default 4: cycles allowed for tx_ready to fall after tx_start.
REQ-003 The block SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 The block SHALL have port req, input, 4: per-requester byte request; held until matching ack.
REQ-006 The block SHALL have port req_data, input, 32: byte for requester i on bits [8i+7:8i].
REQ-007 The block SHALL have port lock, input, 4: requester i asks to keep the grant across bytes (message framing).
REQ-008 The block SHALL have port ack, output, 4: one-cycle pulse, byte from requester i accepted.
REQ-009 The block SHALL have port grant, output, 4: one-hot current/last owner; zero when no owner.
REQ-010 The block SHALL have port tx_data, output, 8: byte to the uart transmitter.
REQ-011 The block SHALL have port tx_start, output, 1: one-cycle start pulse to the transmitter.
REQ-012 The block SHALL have port tx_ready, input, 1: transmitter idle.
REQ-013 The block SHALL have port busy, output, 1: FSM not in IDLE.
REQ-014 The block SHALL have port err, output, 2: sticky flags; bit0 start timeout, bit1 lock timeout; cleared only by reset.

Function
REQ-015 FSM states SHALL be IDLE, LAUNCH, WAIT_LOW, WAIT_HIGH.
REQ-016 In IDLE with tx_ready=1 and an eligible req, the block SHALL select a winner, latch its byte into tx_data, pulse ack[winner], set grant, and go to LAUNCH in the same cycle.
REQ-017 Eligibility SHALL be: if a lock owner exists, only that requester; otherwise all req bits.
REQ-018 Without an owner, the winner SHALL be the first set req bit at or after priority pointer ptr, searching upward modulo 4.
REQ-019 After an unlocked accept of requester i, ptr SHALL become (i+1) mod 4; while locked, ptr SHALL not change.
REQ-020 If lock[i] is high at accept, i SHALL become lock owner; ownership SHALL end in the first IDLE cycle in which lock[owner] is low, and ptr SHALL then become (owner+1) mod 4.
REQ-021 In LAUNCH, tx_start SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT_LOW.
REQ-022 In WAIT_LOW, tx_ready=0 SHALL move the FSM to WAIT_HIGH; if tx_ready stays 1 for START_TIMEOUT cycles, err[0] SHALL be set and the FSM SHALL return to IDLE.
REQ-023 In WAIT_HIGH, tx_ready=1 SHALL return the FSM to IDLE; there is no timeout.
REQ-024 In IDLE, while an owner exists with req[owner]=0 and lock[owner]=1, an idle counter SHALL increment; reaching LOCK_TIMEOUT SHALL clear ownership, set err[1], and reset the counter.
REQ-025 The idle counter SHALL reset to 0 on any accept or ownership release.
REQ-026 Requests arriving while busy SHALL wait; they are not dropped, and no ack is issued outside IDLE.
REQ-027 Minimum spacing between acks SHALL be 4 cycles (IDLE, LAUNCH, WAIT_LOW, WAIT_HIGH).
REQ-028 tx_data SHALL hold its latched value until the next accept.

Reset
REQ-029 While rst=1 the block SHALL force state=IDLE, ack=0, tx_start=0, tx_data=0, grant=0, busy=0, err=0, ptr=0, no owner, and idle counter=0.
REQ-030 Reset asserted mid-transfer SHALL abort with no further tx_start; after reset, the first accept SHALL require tx_ready=1.

Verification
REQ-031 Scenario: req=4'b1111, no lock, transmitter model with 10-cycle busy -> acks in order 0,1,2,3,0; one tx_start per ack; tx_data equals the matching req_data byte.
REQ-032 Scenario: req[2] with lock[2]=1 sending 3 bytes 0x41,0x42,0x43 while req[0] is held -> all three bytes from requester 2 before any ack[0]; ack[0] follows the first IDLE cycle with lock[2]=0.
REQ-033 Scenario: lock[1]=1, req[1]=0, req[3]=1 with LOCK_TIMEOUT=8 -> err[1]=1 after 8 IDLE cycles, then ack[3] on the next cycle.
REQ-034 Scenario: transmitter holds tx_ready=1 permanently after start -> err[0]=1 after 4 WAIT_LOW cycles; FSM back in IDLE; next request is accepted.
REQ-035 Scenario: rst pulsed in WAIT_HIGH -> all outputs 0 on the next cycle; ptr=0 (req=4'b1010 then grants 1 first).
REQ-036 Scenario: tx_ready=0 in IDLE with req pending -> no ack and no tx_start until tx_ready=1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Four-requester round-robin arbiter with lock framing that feeds single bytes to a UART transmitter.
// It uses a start-pulse/ready handshake and keeps sticky error flags for start and lock timeouts.
module uart_tx_arbiter #(
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int START_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  input  logic [3:0]  lock,
  output logic [3:0]  ack,
  output logic [3:0]  grant,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_ready,
  output logic        busy,
  output logic [1:0]  err
);

  localparam int LCW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SCW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_LOW, WAIT_HIGH} state_t;

  state_t           r_state, w_next;
  logic [1:0]       r_ptr, r_owner;
  logic             r_owner_vld;
  logic [LCW-1:0]   r_idle_cnt;
  logic [SCW-1:0]   r_start_cnt;
  logic [7:0]       r_tx_data;
  logic [3:0]       r_grant;
  logic [1:0]       r_err;

  logic [3:0] w_elig;
  logic [1:0] w_win;
  logic       w_found, w_accept, w_tx_start, w_start_to;
  logic       w_lock_hit, w_lock_to, w_release;

  // A lock owner hides everyone else. Scanning downward lets the smallest offset from ptr win.
  always_comb begin
    w_elig  = r_owner_vld ? (req & (4'b0001 << r_owner)) : req;
    w_win   = r_ptr;
    w_found = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (w_elig[r_ptr + 2'(k)]) begin
        w_win   = r_ptr + 2'(k);
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_tx_start = 1'b0;
    w_start_to = 1'b0;
    case (r_state)
      IDLE: begin
        if (tx_ready && w_found) begin
          w_accept = 1'b1;
          w_next   = LAUNCH;
        end
      end
      LAUNCH: begin
        w_tx_start = 1'b1;
        w_next     = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!tx_ready) w_next = WAIT_HIGH;
        else if (r_start_cnt == SCW'(START_TIMEOUT - 1)) begin
          w_start_to = 1'b1;
          w_next     = IDLE;
        end
      end
      WAIT_HIGH: begin
        if (tx_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // An owner that is idle but still locked ages toward a forced release. Dropping lock releases at once.
  assign w_lock_hit = (r_state == IDLE) && r_owner_vld && !req[r_owner] && lock[r_owner];
  assign w_lock_to  = w_lock_hit && (r_idle_cnt == LCW'(LOCK_TIMEOUT - 1));
  assign w_release  = (r_state == IDLE) && r_owner_vld && !lock[r_owner] && !w_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_owner     <= '0;
      r_owner_vld <= 1'b0;
      r_idle_cnt  <= '0;
      r_start_cnt <= '0;
      r_tx_data   <= '0;
      r_grant     <= '0;
      r_err       <= '0;
    end else begin
      if (w_accept) begin
        r_tx_data  <= req_data[{w_win, 3'b000} +: 8];
        r_grant    <= 4'b0001 << w_win;
        r_idle_cnt <= '0;
        if (lock[w_win]) begin
          r_owner_vld <= 1'b1;
          r_owner     <= w_win;
        end else begin
          r_owner_vld <= 1'b0;
          r_ptr       <= w_win + 2'd1;
        end
      end else if (w_release || w_lock_to) begin
        r_owner_vld <= 1'b0;
        r_ptr       <= r_owner + 2'd1;
        r_idle_cnt  <= '0;
        if (w_lock_to) r_err[1] <= 1'b1;
      end else if (w_lock_hit) begin
        r_idle_cnt <= r_idle_cnt + LCW'(1);
      end

      if (w_start_to) r_err[0] <= 1'b1;

      if (r_state == WAIT_LOW && tx_ready) r_start_cnt <= r_start_cnt + SCW'(1);
      else                                 r_start_cnt <= '0;
    end
  end

  // Combinational outputs are masked by rst so that nothing leaks out while reset is held.
  assign ack      = (w_accept && !rst) ? (4'b0001 << w_win) : 4'b0000;
  assign tx_start = w_tx_start && !rst;
  assign busy     = (r_state != IDLE) && !rst;
  assign grant    = r_grant;
  assign tx_data  = r_tx_data;
  assign err      = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter. It models a transmitter that stays busy for 10 cycles.
// The bench covers round-robin order, lock framing, both timeouts, a mid-transfer reset, and the wait on a held-low ready.
module tb_uart_tx_arbiter;

  localparam int BUSY = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, lock, ack, grant;
  logic [31:0] req_data;
  logic [7:0]  tx_data;
  logic        tx_start, tx_ready, busy;
  logic [1:0]  err;

  int n_chk = 0;
  int n_err = 0;

  bit tx_stuck     = 1'b0;
  bit tx_force_low = 1'b0;
  int tx_cnt       = 0;

  uart_tx_arbiter #(.LOCK_TIMEOUT(8), .START_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .lock(lock),
    .ack(ack), .grant(grant), .tx_data(tx_data), .tx_start(tx_start),
    .tx_ready(tx_ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Transmitter model: it goes not-ready for BUSY cycles after every start pulse.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (tx_force_low)  tx_ready = 1'b0;
      else if (tx_stuck) tx_ready = 1'b1;
      else begin
        if (tx_start)        tx_cnt = BUSY;
        else if (tx_cnt > 0) tx_cnt = tx_cnt - 1;
        tx_ready = (tx_cnt == 0);
      end
    end
  end

  task automatic wait_ack(input logic [3:0] exp, input string tag, input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (ack != 4'b0000) break;
    end
    chk(tag, ack, exp);
  endtask

  task automatic wait_idle(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("idle_wait", busy, 0);
  endtask

  initial begin
    int         na, ns;
    int         ids [5];
    logic [7:0] dat [5];
    logic [7:0] exp_b [5];
    bit         early;

    // reset state; req held high checks that ack is masked during reset
    rst = 1'b1; req = 4'hF; lock = 4'h0; req_data = 32'hD4C3B2A1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #1 rst = 1'b0;

    // all four requesting, unlocked: round robin 0,1,2,3,0
    exp_b[0] = 8'hA1; exp_b[1] = 8'hB2; exp_b[2] = 8'hC3; exp_b[3] = 8'hD4; exp_b[4] = 8'hA1;
    na = 0; ns = 0;
    for (int c = 0; c < 400 && ns < 5; c++) begin
      @(negedge clk);
      if (ack != 4'b0000 && na < 5) begin ids[na] = oh2i(ack); na++; end
      if (tx_start && ns < 5) begin
        dat[ns] = tx_data;
        if (ns < na) chk("s1_grant", grant, 32'd1 << ids[ns]);
        ns++;
      end
    end
    @(posedge clk); #1 req = 4'h0;
    chk("s1_nack", na, 5);
    chk("s1_nstart", ns, 5);
    for (int i = 0; i < 5; i++) begin
      chk("s1_order", ids[i], i % 4);
      chk("s1_data", dat[i], exp_b[i]);
    end
    wait_idle(40);

    // requester 2 locked for three bytes while requester 0 waits
    @(posedge clk); #1 req = 4'b0101; lock = 4'b0100; req_data = 32'h0041_0055;
    for (int b = 0; b < 3; b++) begin
      wait_ack(4'b0100, "s2_ack2", 40);
      @(posedge clk); #1;
      if (b < 2) req_data[23:16] = 8'h42 + 8'(b);
      else begin req[2] = 1'b0; lock[2] = 1'b0; end
      @(negedge clk);
      chk("s2_data", tx_data, 8'h41 + 8'(b));
    end
    wait_idle(40);
    chk("s2_rel_noack", ack, 0);
    @(negedge clk);
    chk("s2_ack0", ack, 4'b0001);
    @(posedge clk); #1 req = 4'h0;
    @(negedge clk);
    chk("s2_data0", tx_data, 8'h55);
    wait_idle(40);

    // requester 1 takes lock then goes quiet; 3 waits behind it until lock timeout
    @(posedge clk); #1 req = 4'b0010; lock = 4'b0010; req_data = 32'h0000_7700;
    wait_ack(4'b0010, "s3_ack1", 10);
    @(posedge clk); #1 req = 4'b1000;
    wait_idle(40);
    chk("s3_wait", {err, ack}, 0);
    for (int i = 2; i <= 8; i++) begin
      @(negedge clk);
      chk("s3_wait", {err, ack}, 0);
    end
    @(negedge clk);
    chk("s3_err", err, 2'b10);
    chk("s3_ack3", ack, 4'b1000);
    @(posedge clk); #1 req = 4'h0; lock = 4'h0;
    wait_idle(40);

    // transmitter never drops ready: start timeout after 4 WAIT_LOW cycles
    @(posedge clk); #1 tx_stuck = 1'b1; req = 4'b0001;
    wait_ack(4'b0001, "s4_ack0", 10);
    @(posedge clk); #1 req = 4'h0;
    @(negedge clk);
    chk("s4_launch", tx_start, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("s4_waitlow", {busy, tx_start, err[0]}, 3'b100);
    end
    @(negedge clk);
    chk("s4_idle", busy, 0);
    chk("s4_err", err, 2'b11);
    @(posedge clk); #1 tx_stuck = 1'b0; req = 4'b0010;
    wait_ack(4'b0010, "s4_next", 10);
    @(posedge clk); #1 req = 4'h0;
    wait_idle(40);

    // reset during WAIT_HIGH; pointer returns to 0 so requester 1 beats 3
    @(posedge clk); #1 req = 4'b0100;
    wait_ack(4'b0100, "s5_ack2", 10);
    @(posedge clk); #1 req = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("s5_busy", busy, 1);
    @(posedge clk); #1 rst = 1'b1; req = 4'b1010;
    @(negedge clk);
    chk("s5_rst_ack", ack, 0);
    @(posedge clk);
    @(negedge clk);
    chk("s5_zero", {ack, grant, tx_data, tx_start, busy, err}, 0);
    @(posedge clk); #1 rst = 1'b0;
    early = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (ack != 4'b0000) break;
      if (tx_start) early = 1'b1;
    end
    chk("s5_first", ack, 4'b0010);
    chk("s5_rdy", tx_ready, 1);
    chk("s5_nostart", early, 0);
    @(posedge clk); #1 req = 4'b1000;
    wait_ack(4'b1000, "s5_second", 40);
    @(posedge clk); #1 req = 4'h0;
    wait_idle(40);

    // ready held low in IDLE: request must wait
    @(posedge clk); #1 tx_force_low = 1'b1; req = 4'b0001; req_data = 32'h0000_00E6;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("s6_hold", {ack, tx_start}, 0);
    end
    @(posedge clk); #1 tx_force_low = 1'b0;
    wait_ack(4'b0001, "s6_ack", 4);
    @(posedge clk); #1 req = 4'h0;
    @(negedge clk);
    chk("s6_start", tx_start, 1);
    chk("s6_data", tx_data, 8'hE6);
    wait_idle(40);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule
